// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared types and constants for the DDS tone generator:
//               phase quadrant encoding, dither LFSR seed/taps, pipeline
//               latency and the quarter-wave sine table generator.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

  // Top two phase bits select the quarter of the sine period.
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,  // rising, positive
    QUAD_1 = 2'd1,  // falling, positive (mirrored index)
    QUAD_2 = 2'd2,  // falling, negative
    QUAD_3 = 2'd3   // rising, negative (mirrored index)
  } quad_t;

  // Galois LFSR x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam int          c_lfsr_w    = 16;
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  // Edges from the accepting edge to the edge that raises out_valid.
  localparam int c_pipe_latency = 3;

  localparam real c_pi = 3.14159265358979323846;

  // One step of the dither LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ c_lfsr_taps) : (s >> 1);
  endfunction

  // Quarter-wave entry k, sampled at mid-bin so that entry 0 is never zero
  // and the peak stays at full-scale minus one (negation cannot overflow).
  function automatic int quarter_sine_value(input int k, input int aw, input int sw);
    real amp;
    real ang;
    amp = (2.0 ** (sw - 1)) - 1.0;
    ang = 2.0 * c_pi * ($itor(k) + 0.5) / (2.0 ** (aw + 2));
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/quarter_sine_rom.sv
`default_nettype none
// ============================================================================
// Module      : quarter_sine_rom
// Description : Quarter-wave sine table with one synchronous read port per
//               channel. Entries are computed at elaboration from the
//               mid-bin sine formula in dds_pkg.
// Revision    : 1.0 - initial release
// ============================================================================
module quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int PORTS    = 2,
  parameter int LUT_AW   = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                             clk_audio,
  input  logic [PORTS-1:0][LUT_AW-1:0]     addr,
  output logic [PORTS-1:0][SAMPLE_W-1:0]   data
);

  logic [SAMPLE_W-1:0] w_table [2**LUT_AW];

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_entry
    assign w_table[k] = SAMPLE_W'(quarter_sine_value(k, LUT_AW, SAMPLE_W));
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    // Registered read: data is valid one edge after the address.
    always_ff @(posedge clk_audio) begin
      data[p] <= w_table[addr[p]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dds_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : dds_tone_gen
// Description : Multi-channel direct digital synthesis tone generator.
//               Per-channel phase accumulators, quarter-wave sine lookup,
//               amplitude scaling and a held output register with overrun.
//               Pipeline: address reg -> table read -> scale -> output.
//               Build option DDS_TONE_GEN_DITHER_EN adds LFSR phase dither
//               to the lookup phase (the accumulators are never dithered).
// Revision    : 1.0 - initial release
// ============================================================================
module dds_tone_gen
  import dds_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 24,
  parameter int LUT_AW   = 8,
  parameter int SAMPLE_W = 16,
  parameter int AMP_W    = 8
) (
  input  logic                                   clk_audio,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic                                   sample_tick,
  input  logic                                   phase_sync,
  input  logic [CHANNELS-1:0][PHASE_W-1:0]       tuning_word,
  input  logic [CHANNELS-1:0][AMP_W-1:0]         amplitude,
  input  logic                                   out_ready,
  input  logic                                   overrun_clr,
  output logic                                   out_valid,
  output logic signed [CHANNELS-1:0][SAMPLE_W-1:0] level,
  output logic                                   overrun
);

  localparam int c_dith_w = PHASE_W - LUT_AW - 2;
  localparam int c_dith_n = (c_dith_w < c_lfsr_w) ? c_dith_w : c_lfsr_w;
  localparam int c_prod_w = SAMPLE_W + AMP_W + 1;

  logic                               w_accept;
  logic [PHASE_W-1:0]                 w_dither;
  logic [CHANNELS-1:0][PHASE_W-1:0]   r_phase;
  logic [CHANNELS-1:0][PHASE_W-1:0]   w_lookup;
  logic [CHANNELS-1:0][LUT_AW-1:0]    w_addr;
  logic [CHANNELS-1:0]                w_neg;

  logic                               r_s1_valid;
  logic [CHANNELS-1:0][LUT_AW-1:0]    r_s1_addr;
  logic [CHANNELS-1:0]                r_s1_neg;
  logic [CHANNELS-1:0][AMP_W-1:0]     r_s1_amp;

  logic [CHANNELS-1:0][SAMPLE_W-1:0]  w_rom_data;
  logic                               r_s2_valid;
  logic [CHANNELS-1:0]                r_s2_neg;
  logic [CHANNELS-1:0][AMP_W-1:0]     r_s2_amp;

  logic [CHANNELS-1:0][SAMPLE_W-1:0]  w_scaled;
  logic                               r_s3_valid;
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  r_s3_sample;

  logic                               w_out_free;
  logic                               w_drop;

  assign w_accept = sample_tick & enable;

  // Signed table value times unsigned gain, arithmetic shift, truncate.
  function automatic logic [SAMPLE_W-1:0] scale_sample(
    input logic signed [SAMPLE_W-1:0] v,
    input logic        [AMP_W-1:0]    a
  );
    logic signed [c_prod_w-1:0] p;
    p = c_prod_w'(v) * c_prod_w'($signed({1'b0, a}));
    return p[AMP_W +: SAMPLE_W];
  endfunction

`ifdef DDS_TONE_GEN_DITHER_EN
  logic [c_lfsr_w-1:0] r_lfsr;

  // Shared dither LFSR; steps once per accepted tick.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= c_lfsr_seed;
    end else if (w_accept) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Low LFSR bits land below the table index bits of the lookup phase.
  always_comb begin
    w_dither = '0;
    for (int i = 0; i < c_dith_n; i++) begin
      w_dither[i] = r_lfsr[i];
    end
  end
`else
  assign w_dither = '0;
`endif

  // Phase accumulators: sync forces zero, an accepted tick then adds the step.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (phase_sync) begin
          r_phase[c] <= w_accept ? tuning_word[c] : {PHASE_W{1'b0}};
        end else if (w_accept) begin
          r_phase[c] <= r_phase[c] + tuning_word[c];
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lookup
    quad_t             w_quad;
    logic [LUT_AW-1:0] w_k;

    assign w_lookup[c] = (phase_sync ? {PHASE_W{1'b0}} : r_phase[c]) + w_dither;
    assign w_quad      = quad_t'(w_lookup[c][PHASE_W-1 -: 2]);
    assign w_k         = w_lookup[c][PHASE_W-3 -: LUT_AW];
    assign w_addr[c]   = ((w_quad == QUAD_1) || (w_quad == QUAD_3)) ? ~w_k : w_k;
    assign w_neg[c]    = (w_quad == QUAD_2) || (w_quad == QUAD_3);
  end

  // Stage 1: capture table address, sign and gain for each accepted tick.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_neg   <= '0;
      r_s1_amp   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_addr <= w_addr;
        r_s1_neg  <= w_neg;
        r_s1_amp  <= amplitude;
      end
    end
  end

  quarter_sine_rom #(
    .PORTS    (CHANNELS),
    .LUT_AW   (LUT_AW),
    .SAMPLE_W (SAMPLE_W)
  ) u_rom (
    .clk_audio (clk_audio),
    .addr      (r_s1_addr),
    .data      (w_rom_data)
  );

  // Stage 2: side-band travels alongside the registered table read.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_neg   <= '0;
      r_s2_amp   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_neg   <= r_s1_neg;
      r_s2_amp   <= r_s1_amp;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_scale
    logic signed [SAMPLE_W-1:0] w_tab;
    assign w_tab       = r_s2_neg[c] ? -$signed(w_rom_data[c]) : $signed(w_rom_data[c]);
    assign w_scaled[c] = scale_sample(w_tab, r_s2_amp[c]);
  end

  // Stage 3: register the scaled samples.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      r_s3_valid  <= 1'b0;
      r_s3_sample <= '0;
    end else begin
      r_s3_valid  <= r_s2_valid;
      r_s3_sample <= w_scaled;
    end
  end

  assign w_out_free = !out_valid || out_ready;
  assign w_drop     = r_s3_valid && !w_out_free;

  // Output register: load when free, otherwise drop the set and flag overrun.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      level     <= '0;
      overrun   <= 1'b0;
    end else begin
      if (r_s3_valid) begin
        if (w_out_free) begin
          level     <= r_s3_sample;
          out_valid <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_tone_gen
// Description : Self-checking bench for dds_tone_gen: directed scenarios and
//               randomized traffic against a sample-set reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_tone_gen;
  import dds_pkg::*;

  localparam int CH  = 2;
  localparam int PW  = 24;
  localparam int LAW = 8;
  localparam int SW  = 16;
  localparam int AW  = 8;
  localparam int DW  = PW - LAW - 2;
  localparam int DN  = (DW < 16) ? DW : 16;

  logic                      clk_audio = 1'b0;
  logic                      reset_n;
  logic                      enable;
  logic                      sample_tick;
  logic                      phase_sync;
  logic [CH-1:0][PW-1:0]     tuning_word;
  logic [CH-1:0][AW-1:0]     amplitude;
  logic                      out_ready;
  logic                      overrun_clr;
  logic                      out_valid;
  logic signed [CH-1:0][SW-1:0] level;
  logic                      overrun;

  always #5 clk_audio = ~clk_audio;

  dds_tone_gen #(
    .CHANNELS (CH), .PHASE_W (PW), .LUT_AW (LAW), .SAMPLE_W (SW), .AMP_W (AW)
  ) dut (
    .clk_audio   (clk_audio),
    .reset_n     (reset_n),
    .enable      (enable),
    .sample_tick (sample_tick),
    .phase_sync  (phase_sync),
    .tuning_word (tuning_word),
    .amplitude   (amplitude),
    .out_ready   (out_ready),
    .overrun_clr (overrun_clr),
    .out_valid   (out_valid),
    .level       (level),
    .overrun     (overrun)
  );

  // Reference model state
  typedef struct packed {
    int                  t;
    logic [CH-1:0][SW-1:0] s;
  } set_t;

  set_t                  m_pend[$];
  logic [PW-1:0]         m_phase [CH];
  logic [CH-1:0][SW-1:0] m_level;
  logic                  m_valid;
  logic                  m_ovr;
  logic [15:0]           m_lfsr;
  int                    cyc;
  int                    n_vec;
  int                    n_err;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Full-period sine evaluated at the mid-bin of the top LAW+2 phase bits,
  // rounded half away from zero, then gain-scaled with floor division.
  function automatic int ref_sample(input logic [PW-1:0] ph, input int amp);
    int  m;
    real r;
    int  raw;
    longint p;
    m   = int'(ph >> DW);
    r   = (2.0 ** (SW - 1) - 1.0) * $sin(2.0 * c_pi * ($itor(m) + 0.5) / (2.0 ** (LAW + 2)));
    raw = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    p   = longint'(raw) * longint'(amp);
    return int'(p >>> AW);
  endfunction

  task automatic model_clear();
    m_pend.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_level = '0;
    m_lfsr  = 16'hACE1;
    for (int c = 0; c < CH; c++) m_phase[c] = '0;
  endtask

  task automatic compare_all();
    check("out_valid", longint'(out_valid), longint'(m_valid));
    check("overrun", longint'(overrun), longint'(m_ovr));
    for (int c = 0; c < CH; c++) begin
      check("level", longint'($signed(level[c])), longint'($signed(m_level[c])));
      check("phase", longint'(dut.r_phase[c]), longint'(m_phase[c]));
    end
`ifdef DDS_TONE_GEN_DITHER_EN
    check("lfsr", longint'(dut.r_lfsr), longint'(m_lfsr));
`endif
  endtask

  // One clock: drive inputs, predict the next edge, then compare.
  task automatic cycle(input bit tick, input bit en, input bit sync, input bit rdy, input bit clr);
    bit            arrive;
    bit            set_ovr;
    bit            acc;
    set_t          s;
    logic [PW-1:0] ph;
    logic [PW-1:0] dith;
    sample_tick = tick;
    enable      = en;
    phase_sync  = sync;
    out_ready   = rdy;
    overrun_clr = clr;
    cyc++;
    arrive  = (m_pend.size() > 0) && (m_pend[0].t == cyc);
    set_ovr = 1'b0;
    if (arrive) begin
      s = m_pend.pop_front();
      if (!m_valid || rdy) begin
        m_level = s.s;
        m_valid = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    acc  = tick && en;
    dith = '0;
`ifdef DDS_TONE_GEN_DITHER_EN
    dith = PW'(m_lfsr & 16'((1 << DN) - 1));
`endif
    s.t = cyc + c_pipe_latency;
    for (int c = 0; c < CH; c++) begin
      ph = sync ? '0 : m_phase[c];
      s.s[c] = SW'(ref_sample(ph + dith, int'(amplitude[c])));
      if (sync) m_phase[c] = acc ? tuning_word[c] : '0;
      else if (acc) m_phase[c] = ph + tuning_word[c];
    end
    if (acc) begin
      m_pend.push_back(s);
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    @(posedge clk_audio);
    @(negedge clk_audio);
    compare_all();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    enable      = 1'b0;
    phase_sync  = 1'b0;
    overrun_clr = 1'b0;
    #1;
    model_clear();
    compare_all();
    repeat (2) @(negedge clk_audio);
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    reset_n = 1'b0;
    enable = 1'b0; sample_tick = 1'b0; phase_sync = 1'b0;
    out_ready = 1'b1; overrun_clr = 1'b0;
    tuning_word = '0; amplitude = '0;
    model_clear();
    @(negedge clk_audio);
    do_reset();

    // Quadrant walk: quarter-period step on channel 0
    tuning_word[0] = 24'h400000; tuning_word[1] = 24'h123456;
    amplitude[0]   = 8'd255;     amplitude[1]   = 8'd200;
    repeat (4) cycle(1, 1, 0, 1, 0);
`ifndef DDS_TONE_GEN_DITHER_EN
    check("q0_first", longint'($signed(level[0])), 100);
`endif
    repeat (5) cycle(0, 1, 0, 1, 0);

    // Accumulator wrap and mirrored/negated lookup at 0xFFFFFF
    do_reset();
    tuning_word[0] = 24'hFFFFFF;
    cycle(1, 1, 0, 1, 0);
    check("wrap_acc", longint'(dut.r_phase[0]), 64'hFFFFFF);
    cycle(1, 1, 0, 1, 0);
    repeat (3) cycle(0, 1, 0, 1, 0);
`ifndef DDS_TONE_GEN_DITHER_EN
    check("wrap_sample", longint'($signed(level[0])), -101);
`endif
    repeat (2) cycle(0, 1, 0, 1, 0);

    // Back-pressure: second set dropped, overrun raised then cleared
    do_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    repeat (4) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    repeat (3) cycle(0, 1, 0, 1, 0);

    // Phase sync together with a tick
    do_reset();
    tuning_word[0] = 24'h100000;
    repeat (3) cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 1, 1, 0);
    check("sync_acc", longint'(dut.r_phase[0]), 64'h100000);
    repeat (4) cycle(0, 1, 0, 1, 0);

    // Ignored ticks while disabled; in-flight set survives enable drop
    cycle(1, 1, 0, 1, 0);
    repeat (5) cycle(1, 0, 0, 1, 0);

    // Reset while a sample is in flight
    cycle(1, 1, 0, 1, 0);
    do_reset();
    repeat (5) cycle(0, 1, 0, 1, 0);

    // Identical channels
    tuning_word[0] = 24'h012345; tuning_word[1] = 24'h012345;
    amplitude[0]   = 8'd173;     amplitude[1]   = 8'd173;
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(1)), 1'($urandom_range(3) != 0), 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 5) begin
        for (int c = 0; c < CH; c++) begin
          tuning_word[c] = PW'($urandom);
          amplitude[c]   = AW'($urandom);
        end
      end
      if ($urandom_range(999) < 3) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(1)), $urandom_range(9) < 8, $urandom_range(19) == 0,
              $urandom_range(9) < 7, $urandom_range(9) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
